tcm_mem_arb: RTL and testbench
==============================

Name: tcm_mem_arb

Overview:
- Two-port arbiter and sequencer in front of the single-port 64-bit TCM RAM (512 words, read-first, 1-cycle registered read).
- Port 0 is the CPU data/LSU port. Port 1 is the AXI/DMA slave port.
- Owns RAM address/write-strobe generation, address decode against the TCM window, per-port response routing with backpressure, and starvation protection for port 1.

Parameters:
- BASE_ADDR, 32'h0000_0000, TCM base byte address; window is 4KB, so bits [31:12] must match.
- STARVE_MAX, 4, consecutive cycles port 1 may wait while port 0 is granted before port 1 is forced to win (range 1..15).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- p0_req_i, p1_req_i  in  1  request valid
- p0_addr_i, p1_addr_i  in  32  byte address; bits [2:0] ignored
- p0_wdata_i, p1_wdata_i  in  64  write data
- p0_wstrb_i, p1_wstrb_i  in  8  byte write strobes; all-zero means read
- p0_accept_o, p1_accept_o  out  1  request accepted this cycle
- p0_resp_valid_o, p1_resp_valid_o  out  1  response valid
- p0_resp_ready_i, p1_resp_ready_i  in  1  response consumed
- p0_resp_data_o, p1_resp_data_o  out  64  read data; for writes, the pre-write word
- p0_resp_err_o, p1_resp_err_o  out  1  address outside the TCM window
- ram_addr_o  out  14  RAM word index, driven as {5'b0, addr[11:3]}
- ram_data_o  out  64  RAM write data
- ram_wr_o  out  8  RAM byte write enables
- ram_data_i  in  64  RAM registered read data

Behaviour:
- Reset (rst_i high at a clock edge): all accept_o, resp_valid_o and ram_wr_o are 0 in that cycle and the next. pend0/pend1, hold0/hold1 and starve_cnt clear to 0. resp_data_o and resp_err_o are 0. In-flight responses are dropped.
- Eligibility of port p: req_p && !hold_valid_p && (!pend_p || resp_ready_p). The combinational ready→accept path is intentional and permits back-to-back grants.
- Grant:
  - If both ports are eligible, port 0 wins, unless starve_cnt == STARVE_MAX, in which case port 1 wins.
  - At most one accept per cycle.
  - accept_p is high exactly when port p is granted.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, when port 1 is eligible and port 0 is granted.
  - Clears when port 1 is granted or p1_req_i is low.
- RAM drive:
  - ram_addr_o comes from the granted port, or from port 0 when idle.
  - ram_data_o comes from the granted wdata.
  - ram_wr_o = granted wstrb if the address is in window, else 8'h00. It is also 8'h00 when there is no grant.
- Decode: in-window when addr[31:12] == BASE_ADDR[31:12]. An out-of-window request is still accepted and consumes a slot; its response has err=1 and data=0.
- Response (1-cycle latency):
  - A grant at cycle t sets pend_p and err_q_p for cycle t+1.
  - At t+1, resp_valid_p = 1 and the response comes directly from ram_data_i (err from err_q_p).
- Backpressure:
  - If pend_p && !resp_ready_p, capture data/err into hold_p and set hold_valid_p.
  - While hold_valid_p is set, resp_valid_p = 1 and the response comes from hold_p.
  - hold_valid_p clears when resp_ready_p is high.
- Response mux priority: hold_p over the direct RAM path. The invariant hold_valid_p && pend_p never occurs; the verifier asserts it.
- Responses per port are strictly in order, and there is at most 1 outstanding response plus 0 held (or 0 outstanding plus 1 held) per port.
- Read-first semantics: a write's response returns the old word. A read issued the cycle after a write to the same word returns the new data.
- Each pend_p is a 1-bit state flag per port; there is no other FSM.

Decomposition:
- Shared package tcm_pkg:
  - TCM_WORDS = 512, TCM_ADDR_W = 14, TCM_DATA_W = 64, TCM_STRB_W = 8.
  - tcm_req_t struct {addr, wdata, wstrb}.
  - tcm_resp_t struct {data, err}.
- One sub-module, tcm_resp_slot, instantiated per port. It holds pend/err_q/hold/hold_valid and produces resp_valid/data/err and the "can accept" term.
- The arbiter top holds the grant logic, starve_cnt, decode and RAM drive.

Test Plan:
- Single read, port 0, addr 0x18, RAM word 3 = 64'hDEAD_BEEF_0123_4567, ready=1 → accept in cycle t; resp_valid at t+1 with that data, err=0.
- Write from port 1, addr 0x20, wstrb 8'h0F, wdata 64'h1111_2222_3333_4444 → ram_wr_o = 8'h0F at grant. Read the next cycle returns the upper 32 bits unchanged and the lower 32 bits = 0x3333_4444.
- Both ports request continuously with STARVE_MAX = 4 → the grant sequence is P0,P0,P0,P0,P1, repeating; no cycle has both accepts high.
- Port 0 issues a read with resp_ready low for 3 cycles → the response is held with stable data; p0_accept_o stays 0 while the hold is full even if p0_req_i is high; one cycle after ready rises the next accept occurs.
- Port 1 accesses addr 0x1000_0000 with BASE_ADDR = 0 → accepted, ram_wr_o = 0, response err=1, data=0, RAM contents unchanged.
- rst_i asserted for 1 cycle while a response is held on port 0 → resp_valid drops the next cycle, starve_cnt = 0, and the next request is accepted normally.

Source files
------------

// File: rtl/tcm_pkg.sv
// Shared types and constants for the TCM arbiter slice.
//   TCM_*      : RAM geometry (512 x 64-bit words, 14-bit word address port)
//   tcm_req_t  : one port's request payload (byte address, write data, strobes)
//   tcm_resp_t : one port's response payload (read data, decode error)
//   in_window  : true when a byte address falls in the 4KB TCM window
//   word_index : RAM word index for a byte address
package tcm_pkg;

    localparam int TCM_WORDS  = 512;
    localparam int TCM_ADDR_W = 14;
    localparam int TCM_DATA_W = 64;
    localparam int TCM_STRB_W = 8;

    typedef struct packed {
        logic [31:0]           addr;
        logic [TCM_DATA_W-1:0] wdata;
        logic [TCM_STRB_W-1:0] wstrb;
    } tcm_req_t;

    typedef struct packed {
        logic [TCM_DATA_W-1:0] data;
        logic                  err;
    } tcm_resp_t;

    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:12] == base[31:12];
    endfunction

    // Byte address -> word index; bits [2:0] select a byte within the word.
    function automatic logic [TCM_ADDR_W-1:0] word_index(input logic [31:0] addr);
        return {5'b0, addr[11:3]};
    endfunction

endpackage

// File: rtl/tcm_mem_arb_if.sv
// Request/response bundle for one TCM arbiter port.
//   master : requester side (CPU LSU or AXI/DMA slave)
//   slave  : arbiter side
// Signals: req/addr/wdata/wstrb (request, wstrb==0 means read), accept,
// resp_valid/resp_ready/resp_data/resp_err (response with backpressure).
interface tcm_mem_arb_if;
    import tcm_pkg::*;

    logic                  req;
    logic [31:0]           addr;
    logic [TCM_DATA_W-1:0] wdata;
    logic [TCM_STRB_W-1:0] wstrb;
    logic                  accept;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [TCM_DATA_W-1:0] resp_data;
    logic                  resp_err;

    modport master (
        output req, addr, wdata, wstrb, resp_ready,
        input  accept, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req, addr, wdata, wstrb, resp_ready,
        output accept, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/tcm_resp_slot.sv
// Per-port response slot: one in-flight response (pend) plus one skid
// entry (hold) for when the requester is not ready.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   grant_i        : port granted this cycle
//   err_i          : granted request is outside the TCM window
//   resp_ready_i   : requester consumes the response
//   ram_data_i     : registered RAM read data (valid the cycle after grant)
//   can_accept_o   : slot can take a new grant this cycle
//   resp_valid_o   : response valid
//   resp_o         : response data/err
module tcm_resp_slot
    import tcm_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  grant_i,
    input  logic                  err_i,
    input  logic                  resp_ready_i,
    input  logic [TCM_DATA_W-1:0] ram_data_i,
    output logic                  can_accept_o,
    output logic                  resp_valid_o,
    output tcm_resp_t             resp_o
);

    logic      pend;
    logic      err_q;
    logic      hold_valid;
    tcm_resp_t hold;
    tcm_resp_t direct;

    // Out-of-window accesses return zero data regardless of what the RAM read.
    always_comb begin
        direct.data = err_q ? '0 : ram_data_i;
        direct.err  = err_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend       <= 1'b0;
            err_q      <= 1'b0;
            hold_valid <= 1'b0;
            hold       <= '0;
        end else begin
            pend <= grant_i;
            if (grant_i)
                err_q <= err_i;
            if (pend && !resp_ready_i) begin
                hold_valid <= 1'b1;
                hold       <= direct;
            end else if (hold_valid && resp_ready_i) begin
                hold_valid <= 1'b0;
            end
        end
    end

    // A pending response frees the slot in the same cycle it is consumed.
    assign can_accept_o = !hold_valid && (!pend || resp_ready_i);
    assign resp_valid_o = !rst_i && (hold_valid || pend);

    always_comb begin
        resp_o = '0;
        if (!rst_i) begin
            if (hold_valid)
                resp_o = hold;
            else if (pend)
                resp_o = direct;
        end
    end

endmodule

// File: rtl/tcm_mem_arb.sv
// Two-port arbiter/sequencer in front of the single-port 64-bit TCM RAM.
// Port 0 (CPU LSU) has priority; port 1 (AXI/DMA) is forced to win after
// waiting STARVE_MAX consecutive cycles while port 0 is granted.
//   clk_i, rst_i : clock, synchronous active-high reset
//   p0, p1       : request/response ports (slave modport)
//   ram_addr_o   : RAM word index
//   ram_data_o   : RAM write data
//   ram_wr_o     : RAM byte write enables (zero when idle or out of window)
//   ram_data_i   : RAM registered read data (read-first)
module tcm_mem_arb
    import tcm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          STARVE_MAX = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    tcm_mem_arb_if.slave          p0,
    tcm_mem_arb_if.slave          p1,
    output logic [TCM_ADDR_W-1:0] ram_addr_o,
    output logic [TCM_DATA_W-1:0] ram_data_o,
    output logic [TCM_STRB_W-1:0] ram_wr_o,
    input  logic [TCM_DATA_W-1:0] ram_data_i
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    tcm_req_t  req0, req1, sel_req;
    tcm_resp_t resp0, resp1;
    logic      can0, can1, valid0, valid1;
    logic      elig0, elig1, grant0, grant1;
    logic      rst_q;
    logic [3:0] starve_cnt;

    assign req0 = '{addr: p0.addr, wdata: p0.wdata, wstrb: p0.wstrb};
    assign req1 = '{addr: p1.addr, wdata: p1.wdata, wstrb: p1.wstrb};

    // Grants stay off in the reset cycle and the one after it.
    always_ff @(posedge clk_i) begin
        rst_q <= rst_i;
    end

    always_comb begin
        elig0  = !rst_i && !rst_q && p0.req && can0;
        elig1  = !rst_i && !rst_q && p1.req && can1;
        grant1 = elig1 && (!elig0 || starve_cnt == STARVE_LIM);
        grant0 = elig0 && !grant1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || grant1 || !p1.req)
            starve_cnt <= '0;
        else if (elig1 && grant0 && starve_cnt != STARVE_LIM)
            starve_cnt <= starve_cnt + 4'd1;
    end

    // Port 0 drives the address bus when idle.
    always_comb begin
        sel_req    = grant1 ? req1 : req0;
        ram_addr_o = word_index(sel_req.addr);
        ram_data_o = sel_req.wdata;
        ram_wr_o   = ((grant0 || grant1) && in_window(sel_req.addr, BASE_ADDR))
                     ? sel_req.wstrb : '0;
    end

    tcm_resp_slot u_slot0 (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .grant_i      (grant0),
        .err_i        (!in_window(req0.addr, BASE_ADDR)),
        .resp_ready_i (p0.resp_ready),
        .ram_data_i   (ram_data_i),
        .can_accept_o (can0),
        .resp_valid_o (valid0),
        .resp_o       (resp0)
    );

    tcm_resp_slot u_slot1 (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .grant_i      (grant1),
        .err_i        (!in_window(req1.addr, BASE_ADDR)),
        .resp_ready_i (p1.resp_ready),
        .ram_data_i   (ram_data_i),
        .can_accept_o (can1),
        .resp_valid_o (valid1),
        .resp_o       (resp1)
    );

    assign p0.accept     = grant0;
    assign p0.resp_valid = valid0;
    assign p0.resp_data  = resp0.data;
    assign p0.resp_err   = resp0.err;
    assign p1.accept     = grant1;
    assign p1.resp_valid = valid1;
    assign p1.resp_data  = resp1.data;
    assign p1.resp_err   = resp1.err;

endmodule

// File: tb/tb_tcm_mem_arb.sv
// Testbench for tcm_mem_arb: read-first RAM model, reference memory and
// per-port response scoreboards, plus directed arbitration/hold/reset checks.
module tb_tcm_mem_arb;
    import tcm_pkg::*;

    logic        clk_i;
    logic        rst_i;
    logic        ram_load;
    logic [13:0] ram_addr;
    logic [63:0] ram_data_w;
    logic [7:0]  ram_wr;
    logic [63:0] ram_rdata;

    tcm_mem_arb_if if0 ();
    tcm_mem_arb_if if1 ();

    tcm_mem_arb #(.BASE_ADDR(32'h0000_0000), .STARVE_MAX(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .p0         (if0),
        .p1         (if1),
        .ram_addr_o (ram_addr),
        .ram_data_o (ram_data_w),
        .ram_wr_o   (ram_wr),
        .ram_data_i (ram_rdata)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] init_word(input int i);
        if (i == 3) return 64'hDEAD_BEEF_0123_4567;
        return {32'hC0DE_0000 | 32'(i), 32'h0BAD_0000 | 32'(i)};
    endfunction

    // Read-first RAM with 1-cycle registered read.
    logic [63:0] ram [0:511];
    always @(posedge clk_i) begin
        if (ram_load) begin
            for (int i = 0; i < 512; i++) ram[i] <= init_word(i);
            ram_rdata <= '0;
        end else begin
            ram_rdata <= ram[ram_addr[8:0]];
            for (int b = 0; b < 8; b++)
                if (ram_wr[b]) ram[ram_addr[8:0]][b*8 +: 8] <= ram_data_w[b*8 +: 8];
        end
    end

    // Reference memory, updated from port-side stimulus at accept time.
    logic [63:0] refm [0:511];
    tcm_resp_t q0[$];
    tcm_resp_t q1[$];

    function automatic void ref_access(input logic [31:0] addr, input logic [63:0] wdata,
                                       input logic [7:0] wstrb, output tcm_resp_t e,
                                       output logic [7:0] ewr);
        int idx;
        idx = int'(addr[11:3]);
        if (addr[31:12] != 20'h0) begin
            e.data = '0; e.err = 1'b1; ewr = 8'h00;
        end else begin
            e.data = refm[idx]; e.err = 1'b0; ewr = wstrb;
            for (int b = 0; b < 8; b++)
                if (wstrb[b]) refm[idx][b*8 +: 8] = wdata[b*8 +: 8];
        end
    endfunction

    always @(negedge clk_i) begin
        tcm_resp_t  e;
        logic [7:0] ewr;
        if (ram_load)
            for (int i = 0; i < 512; i++) refm[i] = init_word(i);
        if (rst_i) begin
            q0.delete();
            q1.delete();
        end else begin
            check_eq("one_accept", 64'(if0.accept & if1.accept), 64'd0);
            check_eq("hold_pend0", 64'(dut.u_slot0.hold_valid & dut.u_slot0.pend), 64'd0);
            check_eq("hold_pend1", 64'(dut.u_slot1.hold_valid & dut.u_slot1.pend), 64'd0);
            if (if0.resp_valid) begin
                if (q0.size() == 0) check_eq("p0_spurious_resp", 64'd1, 64'd0);
                else begin
                    check_eq("p0_resp_data", if0.resp_data, q0[0].data);
                    check_eq("p0_resp_err", 64'(if0.resp_err), 64'(q0[0].err));
                    if (if0.resp_ready) void'(q0.pop_front());
                end
            end
            if (if1.resp_valid) begin
                if (q1.size() == 0) check_eq("p1_spurious_resp", 64'd1, 64'd0);
                else begin
                    check_eq("p1_resp_data", if1.resp_data, q1[0].data);
                    check_eq("p1_resp_err", 64'(if1.resp_err), 64'(q1[0].err));
                    if (if1.resp_ready) void'(q1.pop_front());
                end
            end
            if (if0.accept) begin
                ref_access(if0.addr, if0.wdata, if0.wstrb, e, ewr);
                check_eq("p0_ram_wr", 64'(ram_wr), 64'(ewr));
                check_eq("p0_ram_addr", 64'(ram_addr), 64'({5'b0, if0.addr[11:3]}));
                check_eq("p0_ram_data", ram_data_w, if0.wdata);
                q0.push_back(e);
            end
            if (if1.accept) begin
                ref_access(if1.addr, if1.wdata, if1.wstrb, e, ewr);
                check_eq("p1_ram_wr", 64'(ram_wr), 64'(ewr));
                check_eq("p1_ram_addr", 64'(ram_addr), 64'({5'b0, if1.addr[11:3]}));
                check_eq("p1_ram_data", ram_data_w, if1.wdata);
                q1.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_p0(input logic req, input logic [31:0] addr, input logic [63:0] wdata,
                          input logic [7:0] wstrb);
        if0.req = req; if0.addr = addr; if0.wdata = wdata; if0.wstrb = wstrb;
    endtask

    task automatic set_p1(input logic req, input logic [31:0] addr, input logic [63:0] wdata,
                          input logic [7:0] wstrb);
        if1.req = req; if1.addr = addr; if1.wdata = wdata; if1.wstrb = wstrb;
    endtask

    // Both ports requesting with starve_cnt starting at 0: P0 x4 then P1.
    task automatic run_starve(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_i);
            check_eq($sformatf("%s_a0_%0d", tag, k), 64'(if0.accept), 64'((k % 5) != 4));
            check_eq($sformatf("%s_a1_%0d", tag, k), 64'(if1.accept), 64'((k % 5) == 4));
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; ram_load = 1'b1;
        set_p0(1'b0, '0, '0, '0); set_p1(1'b0, '0, '0, '0);
        if0.resp_ready = 1'b1; if1.resp_ready = 1'b1;
        tick(); tick();
        @(negedge clk_i);
        check_eq("rst_valid0", 64'(if0.resp_valid), 64'd0);
        check_eq("rst_valid1", 64'(if1.resp_valid), 64'd0);
        check_eq("rst_ram_wr", 64'(ram_wr), 64'd0);
        check_eq("rst_data0", if0.resp_data, 64'd0);
        check_eq("rst_err1", 64'(if1.resp_err), 64'd0);
        tick();
        rst_i = 1'b0; ram_load = 1'b0;

        // Single read, port 0; blocked in the cycle after reset.
        set_p0(1'b1, 32'h18, '0, 8'h00);
        @(negedge clk_i);
        check_eq("post_rst_accept0", 64'(if0.accept), 64'd0);
        tick();
        @(negedge clk_i);
        check_eq("rd_accept0", 64'(if0.accept), 64'd1);
        tick();
        set_p0(1'b0, 32'h18, '0, 8'h00);
        @(negedge clk_i);
        check_eq("rd_valid0", 64'(if0.resp_valid), 64'd1);
        check_eq("rd_data0", if0.resp_data, 64'hDEAD_BEEF_0123_4567);

        // Partial write from port 1, then read-back the next cycle.
        tick();
        set_p1(1'b1, 32'h20, 64'h1111_2222_3333_4444, 8'h0F);
        @(negedge clk_i);
        check_eq("wr_accept1", 64'(if1.accept), 64'd1);
        check_eq("wr_strb", 64'(ram_wr), 64'h0F);
        tick();
        set_p1(1'b1, 32'h20, '0, 8'h00);
        @(negedge clk_i);
        check_eq("rb_accept1", 64'(if1.accept), 64'd1);
        tick();
        set_p1(1'b0, 32'h20, '0, 8'h00);
        @(negedge clk_i);
        check_eq("rb_data1", if1.resp_data, {init_word(4)[63:32], 32'h3333_4444});

        // Starvation protection.
        tick();
        set_p0(1'b1, 32'h18, '0, 8'h00);
        set_p1(1'b1, 32'h28, '0, 8'h00);
        run_starve("starve", 10);
        set_p0(1'b0, 32'h18, '0, 8'h00);
        set_p1(1'b0, 32'h28, '0, 8'h00);
        tick();

        // Backpressure on port 0.
        set_p0(1'b1, 32'h18, '0, 8'h00);
        if0.resp_ready = 1'b0;
        @(negedge clk_i);
        check_eq("hold_accept", 64'(if0.accept), 64'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check_eq($sformatf("hold_block_%0d", k), 64'(if0.accept), 64'd0);
            check_eq($sformatf("hold_valid_%0d", k), 64'(if0.resp_valid), 64'd1);
            tick();
        end
        if0.resp_ready = 1'b1;
        @(negedge clk_i);
        check_eq("hold_release_block", 64'(if0.accept), 64'd0);
        tick();
        @(negedge clk_i);
        check_eq("hold_next_accept", 64'(if0.accept), 64'd1);
        tick();
        set_p0(1'b0, 32'h18, '0, 8'h00);
        tick();

        // Out-of-window write on port 1; RAM word 0 must be untouched.
        set_p1(1'b1, 32'h1000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        @(negedge clk_i);
        check_eq("oow_accept1", 64'(if1.accept), 64'd1);
        check_eq("oow_ram_wr", 64'(ram_wr), 64'd0);
        tick();
        set_p1(1'b0, 32'h0, '0, 8'h00);
        set_p0(1'b1, 32'h0, '0, 8'h00);
        @(negedge clk_i);
        check_eq("oow_err1", 64'(if1.resp_err), 64'd1);
        check_eq("oow_data1", if1.resp_data, 64'd0);
        tick();
        set_p0(1'b0, 32'h0, '0, 8'h00);
        @(negedge clk_i);
        check_eq("oow_word0", if0.resp_data, init_word(0));
        tick();

        // Reset mid starvation sequence: arbitration restarts from scratch.
        set_p0(1'b1, 32'h30, '0, 8'h00);
        set_p1(1'b1, 32'h38, '0, 8'h00);
        run_starve("pre_rst", 3);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_eq("rst_cyc_a0", 64'(if0.accept), 64'd0);
        check_eq("rst_cyc_a1", 64'(if1.accept), 64'd0);
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("rst_next_a0", 64'(if0.accept), 64'd0);
        check_eq("rst_next_v0", 64'(if0.resp_valid), 64'd0);
        check_eq("rst_starve_cnt", 64'(dut.starve_cnt), 64'd0);
        tick();
        run_starve("post_rst", 5);
        set_p0(1'b0, 32'h30, '0, 8'h00);
        set_p1(1'b0, 32'h38, '0, 8'h00);
        tick();

        // Reset while port 0 holds a response.
        set_p0(1'b1, 32'h18, '0, 8'h00);
        if0.resp_ready = 1'b0;
        @(negedge clk_i);
        check_eq("rh_accept", 64'(if0.accept), 64'd1);
        tick();
        set_p0(1'b0, 32'h18, '0, 8'h00);
        tick();
        @(negedge clk_i);
        check_eq("rh_held_valid", 64'(if0.resp_valid), 64'd1);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        if0.resp_ready = 1'b1;
        set_p0(1'b1, 32'h40, '0, 8'h00);
        @(negedge clk_i);
        check_eq("rh_valid_dropped", 64'(if0.resp_valid), 64'd0);
        tick();
        @(negedge clk_i);
        check_eq("rh_next_accept", 64'(if0.accept), 64'd1);
        tick();
        set_p0(1'b0, 32'h40, '0, 8'h00);

        for (int k = 0; k < 20 && (q0.size() + q1.size()) != 0; k++) tick();
        check_eq("drain", 64'(q0.size() + q1.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
